// File: rtl/cwc_capture_reader.sv
// Capture-RAM readout engine.
// Streams a 4-byte header (CA FE N_hi N_lo) followed by N samples.
// Each sample is read from the capture RAM and sent as NB bytes, least
// significant byte first. Addresses wrap modulo the RAM depth.
//
// Stream handshake: a byte transfers on a clock edge where m_tvalid and
// m_tready are both high. Once m_tvalid is raised it stays high, and
// m_tdata/m_tlast hold steady, until that transfer happens. m_tvalid
// never depends on m_tready.
module cwc_capture_reader #(
    parameter int DATA_W = 51,
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   sample_cnt,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    // Bytes per sample and byte-shift-register width (pad bits are zero).
    localparam int NB   = (DATA_W + 7) / 8;
    localparam int SH_W = NB * 8;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int WC_W = 2;

    // Largest frame: every location of the RAM once.
    localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_N = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] SEND  = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   n_reg;
    logic [ADDR_W:0]   remaining;
    logic [1:0]        hdr_idx;
    logic [BI_W-1:0]   byte_idx;
    logic [WC_W-1:0]   wait_cnt;
    logic [SH_W-1:0]   shreg;
    logic [15:0]       n16;
    logic              hs;
    logic              last_byte;
    logic              wait_last;
    logic              n_zero;

    assign hs        = m_tvalid && m_tready;
    assign last_byte = (byte_idx == BI_W'(NB - 1));
    assign wait_last = (wait_cnt == WC_W'(RD_LAT - 1));
    assign n_zero    = (n_reg == '0);
    assign n16       = 16'(n_reg);
    assign state_dbg = state;

    // Next-state selection; every exit from a byte state waits for a handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (hs && (hdr_idx == 2'd3)) begin
                    state_nxt = n_zero ? FIN : FETCH;
                end
            end
            FETCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_last) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (hs && last_byte) begin
                    state_nxt = (remaining == ONE_N) ? FIN : FETCH;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: frame parameters, address/count tracking and byte shifter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            n_reg     <= '0;
            remaining <= '0;
            hdr_idx   <= '0;
            byte_idx  <= '0;
            wait_cnt  <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr    <= first_addr;
                        hdr_idx <= '0;
                        if (sample_cnt > MAX_N) begin
                            n_reg     <= MAX_N;
                            remaining <= MAX_N;
                        end else begin
                            n_reg     <= sample_cnt;
                            remaining <= sample_cnt;
                        end
                    end
                end
                HDR: begin
                    if (hs) begin
                        hdr_idx <= hdr_idx + 2'd1;
                    end
                end
                FETCH: begin
                    wait_cnt <= '0;
                    byte_idx <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_last) begin
                        shreg <= SH_W'(ram_rd_data);
                    end
                end
                SEND: begin
                    if (hs) begin
                        shreg    <= shreg >> 8;
                        byte_idx <= byte_idx + 1'b1;
                        if (last_byte) begin
                            addr      <= addr + 1'b1;
                            remaining <= remaining - ONE_N;
                        end
                    end
                end
                default: begin
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only, so they are stable under stall.
    always_comb begin
        m_tvalid    = 1'b0;
        m_tdata     = 8'h00;
        m_tlast     = 1'b0;
        ram_rd_en   = (state == FETCH);
        ram_rd_addr = addr;
        busy        = (state == HDR) || (state == FETCH) ||
                      (state == WAIT) || (state == SEND);
        done        = (state == FIN);
        case (state)
            HDR: begin
                m_tvalid = 1'b1;
                case (hdr_idx)
                    2'd0:    m_tdata = 8'hCA;
                    2'd1:    m_tdata = 8'hFE;
                    2'd2:    m_tdata = n16[15:8];
                    default: m_tdata = n16[7:0];
                endcase
                m_tlast = (hdr_idx == 2'd3) && n_zero;
            end
            SEND: begin
                m_tvalid = 1'b1;
                m_tdata  = shreg[7:0];
                m_tlast  = last_byte && (remaining == ONE_N);
            end
            default: begin
                m_tvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/cwc_capture_reader.md
CWC_CAPTURE_READER -- requirements
Module: cwc_capture_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 51, giving the captured sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 11, giving the capture RAM depth as 2^ADDR_W (2048).
REQ-003 SHALL have parameter RD_LAT, default 1, giving the capture RAM read latency in cycles (range 1..3).
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to begin a readout.
REQ-007 SHALL have port first_addr, input, ADDR_W bits: RAM address of the oldest sample, sampled on an accepted start.
REQ-008 SHALL have port sample_cnt, input, ADDR_W+1 bits: number of samples to send, sampled on an accepted start.
REQ-009 SHALL have port ram_rd_en, output, 1 bit: capture RAM read strobe.
REQ-010 SHALL have port ram_rd_addr, output, ADDR_W bits: capture RAM read address.
REQ-011 SHALL have port ram_rd_data, input, DATA_W bits: RAM data, valid RD_LAT cycles after ram_rd_en.
REQ-012 SHALL have port m_tdata, output, 8 bits: byte stream to the host link.
REQ-013 SHALL have ports m_tvalid (output), m_tready (input) and m_tlast (output), 1 bit each: stream handshake and end-of-frame marker.
REQ-014 SHALL have port busy, output, 1 bit: high from an accepted start until the final byte is accepted.
REQ-015 SHALL have port done, output, 1 bit: single-cycle pulse on the cycle after the final byte handshake.

Function
REQ-016 SHALL define NB = ceil(DATA_W/8) (7 at default); each sample is sent as NB bytes, least-significant byte first, with pad bits above DATA_W sent as 0.
REQ-017 SHALL use FSM states IDLE, HDR, FETCH, WAIT, SEND, FIN.
REQ-018 SHALL accept start only in IDLE; in that cycle it latches first_addr, latches N = min(sample_cnt, 2^ADDR_W), sets busy and moves to HDR; start in any other state is ignored.
REQ-019 In HDR the block SHALL send 4 header bytes: 0xCA, 0xFE, N[15:8], N[7:0] (N zero-extended to 16 bits).
REQ-020 After the header, the block SHALL move to FETCH if N>0 and to FIN if N==0; when N==0, m_tlast SHALL be set on the 4th header byte.
REQ-021 FETCH SHALL assert ram_rd_en for exactly 1 cycle with ram_rd_addr = current address, then move to WAIT.
REQ-022 WAIT SHALL last RD_LAT cycles, capture ram_rd_data into the byte shift register on the last WAIT cycle, and then move to SEND.
REQ-023 SEND SHALL present NB bytes in order, shifting by 8 bits per handshake.
REQ-024 After the NB-th byte of a sample, SEND SHALL go to FETCH if samples remain, otherwise to FIN.
REQ-025 The read address SHALL increment by 1 per sample and wrap modulo 2^ADDR_W (2047 -> 0).
REQ-026 A handshake SHALL occur when m_tvalid && m_tready; while m_tvalid is high and m_tready is low, m_tdata and m_tlast SHALL hold stable.
REQ-027 m_tvalid SHALL stay high until the handshake, and SHALL be low in IDLE, FETCH, WAIT and FIN.
REQ-028 m_tlast SHALL be 1 only on the final byte of the frame: byte NB of sample N when N>0, or header byte 4 when N==0.
REQ-029 FIN SHALL lower busy, pulse done for 1 cycle and return to IDLE; a start arriving in FIN is ignored.
REQ-030 ram_rd_en SHALL be 0 outside FETCH.
REQ-031 Total frame length SHALL be 4 + N*NB bytes.

Reset
REQ-032 While rst_n is low at a clk edge, the block SHALL go to IDLE and drive m_tvalid=0, m_tlast=0, m_tdata=0, ram_rd_en=0, ram_rd_addr=0, busy=0 and done=0.
REQ-033 A reset in the middle of a frame SHALL abandon the frame with no further bytes and no done pulse; a start on the first cycle after rst_n rises SHALL be accepted.

Verification
REQ-034 Scenario 1: first_addr=0x010, sample_cnt=2, RAM[0x010]=51'h1_2345_6789_ABCD, m_tready=1 -> bytes CA FE 00 02 CD AB 89 67 45 23 01, then 7 bytes of RAM[0x011]; tlast on byte 18; done 1 cycle later.
REQ-035 Scenario 2: first_addr=0x7FE, sample_cnt=3 -> reads at 0x7FE, 0x7FF, 0x000 in that order; 25 bytes total.
REQ-036 Scenario 3: sample_cnt=0 -> exactly CA FE 00 00, with tlast on 00 #2; no ram_rd_en ever asserted.
REQ-037 Scenario 4: sample_cnt=4095 -> header N=0x0800, 4+2048*7 bytes; random m_tready stalls -> tdata/tlast stable under stall; second start mid-frame ignored.
REQ-038 Scenario 5: rst_n low during byte 9 of a frame -> next cycle m_tvalid=0, busy=0, no done; new start then produces a full correct frame.
REQ-039 Scenario 6: RD_LAT=3 with a RAM model of latency 3 -> data matches Scenario 1 and exactly 3 WAIT cycles per sample.
